// File: rtl/mul_share_arb.sv
// mul_share_arb: one shift-add W x W unsigned multiplier shared by NUM_REQ
// requesters. A round-robin arbiter picks one request at a time. The
// multiplier then adds one partial-product row per clock. Each product is
// returned tagged with the index of the requester that issued it.
module mul_share_arb #(
    parameter int W       = 8,
    parameter int NUM_REQ = 4,
    localparam int IDW    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*W-1:0] req_a,
    input  logic [NUM_REQ*W-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [IDW-1:0]       res_id,
    output logic [2*W-1:0]       res_p,
    output logic                 busy
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [IDW-1:0]   ptr_q;
    logic [CW-1:0]    cnt_q;
    logic [2*W-1:0]   acc_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [IDW-1:0]   id_q;
    logic             res_valid_q;
    logic [IDW-1:0]   res_id_q;
    logic [2*W-1:0]   res_p_q;
    logic             busy_q;

    logic [W-1:0]       a_arr [NUM_REQ];
    logic [W-1:0]       b_arr [NUM_REQ];
    logic [NUM_REQ-1:0] grant_c;
    logic [IDW-1:0]     grant_id_c;
    logic [IDW-1:0]     idx_c;
    logic               found_c;
    logic               accept_c;
    logic [2*W-1:0]     pp_c;
    logic [2*W-1:0]     acc_d;
    logic [CW-1:0]      cnt_d;
    logic               last_c;

    // Split the flattened operand buses into one slot per requester
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign a_arr[gi] = req_a[gi*W +: W];
        assign b_arr[gi] = req_b[gi*W +: W];
    end

    // Round-robin search: first valid requester at or after ptr, wrapping (NUM_REQ is a power of two)
    always_comb begin
        grant_c    = '0;
        grant_id_c = '0;
        found_c    = 1'b0;
        idx_c      = '0;
        for (int o = 0; o < NUM_REQ; o++) begin
            idx_c = ptr_q + IDW'(o);
            if (!found_c && req_valid[idx_c]) begin
                grant_c[idx_c] = 1'b1;
                grant_id_c     = idx_c;
                found_c        = 1'b1;
            end
        end
    end

    // Grants are only offered while idle; BUSY and DONE hold everyone off
    assign req_ready = (state_q == ST_IDLE) ? grant_c : '0;
    assign accept_c  = (state_q == ST_IDLE) && found_c;

    // One shift-add row per clock: add a<<k when multiplier bit k is set
    always_comb begin
        pp_c   = b_q[cnt_q] ? ({{W{1'b0}}, a_q} << cnt_q) : '0;
        acc_d  = acc_q + pp_c;
        cnt_d  = cnt_q + 1'b1;
        last_c = (cnt_q == CW'(W - 1));
    end

    // Arbitration / multiply sequencer with registered result outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_p_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept_c) begin
                        a_q     <= a_arr[grant_id_c];
                        b_q     <= b_arr[grant_id_c];
                        id_q    <= grant_id_c;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        ptr_q   <= grant_id_c + 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_d;
                    if (last_c) begin
                        // Final row goes straight into the result register
                        res_p_q     <= acc_d;
                        res_id_q    <= id_q;
                        res_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    res_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_p     = res_p_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mul_share_arb.sv
// Directed self-checking bench for mul_share_arb (W=8, NUM_REQ=4).
module tb_mul_share_arb;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_id;
    logic [15:0] res_p;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    mul_share_arb #(.W(8), .NUM_REQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_p     (res_p),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts, and reports on mismatch
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %s got=0x%0h", tag, got);
        end else begin
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
        req_valid[i]    = 1'b1;
    endtask

    // Wait (bounded) for a grant, check it, then step over the accept edge
    task automatic wait_grant(input string tag, input int exp_id);
        int n;
        n = 0;
        #1;
        while (req_ready == 4'b0 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_grant"}, {28'b0, req_ready}, 32'd1 << exp_id);
        tick();
    endtask

    // Called at the accept point; checks latency, product and tag
    task automatic wait_result(input string tag, input int exp_id, input int exp_p);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!res_valid && n < 30);
        check({tag, "_lat"}, n, 8);
        check({tag, "_p"}, {16'b0, res_p}, exp_p);
        check({tag, "_id"}, {30'b0, res_id}, exp_id);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Hand-computed directed vectors
    int vec_a  [3] = '{8'hFF, 8'h00, 8'h08};
    int vec_b  [3] = '{8'hFF, 8'h9A, 8'h09};
    int vec_p  [3] = '{32'hFE01, 0, 72};
    int all_a  [4] = '{1, 2, 4, 15};
    int all_b  [4] = '{1, 3, 5, 15};
    int all_p  [4] = '{1, 6, 20, 225};
    int fair_id[4] = '{0, 2, 0, 2};
    int fair_p [4] = '{9, 100, 9, 100};

    initial begin
        bit seen;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;

        // Reset values
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_res_valid", {31'b0, res_valid}, 0);
        check("rst_res_p", {16'b0, res_p}, 0);
        check("rst_res_id", {30'b0, res_id}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_req_ready", {28'b0, req_ready}, 0);
        rst_n = 1'b1;

        // Single request from requester 1: 7*5
        set_req(1, 8'd7, 8'd5);
        wait_grant("t1", 1);
        req_valid[1] = 1'b0;
        check("t1_busy", {31'b0, busy}, 1);
        check("t1_ready_busy", {28'b0, req_ready}, 0);
        wait_result("t1", 1, 35);
        tick();
        check("t1_valid_after", {31'b0, res_valid}, 0);
        check("t1_busy_after", {31'b0, busy}, 0);
        check("t1_p_kept", {16'b0, res_p}, 35);

        // Extremes from requester 0
        for (int k = 0; k < 3; k++) begin
            set_req(0, vec_a[k][7:0], vec_b[k][7:0]);
            wait_grant($sformatf("ext%0d", k), 0);
            req_valid[0] = 1'b0;
            wait_result($sformatf("ext%0d", k), 0, vec_p[k]);
        end

        // All four at once from ptr=0
        do_reset();
        for (int k = 0; k < 4; k++) set_req(k, all_a[k][7:0], all_b[k][7:0]);
        for (int k = 0; k < 4; k++) begin
            wait_grant($sformatf("all%0d", k), k);
            req_valid[k] = 1'b0;
            wait_result($sformatf("all%0d", k), k, all_p[k]);
        end

        // Fairness: 0 and 2 request continuously
        do_reset();
        set_req(0, 8'd3, 8'd3);
        set_req(2, 8'd10, 8'd10);
        for (int k = 0; k < 4; k++) begin
            wait_grant($sformatf("fair%0d", k), fair_id[k]);
            wait_result($sformatf("fair%0d", k), fair_id[k], fair_p[k]);
        end
        req_valid = '0;
        tick();

        // Backpressure: result held while requester 3 waits
        res_ready = 1'b0;
        set_req(1, 8'd12, 8'd11);
        wait_grant("bp1", 1);
        req_valid[1] = 1'b0;
        set_req(3, 8'd6, 8'd7);
        wait_result("bp1", 1, 132);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("bp_hold%0d_valid", k), {31'b0, res_valid}, 1);
            check($sformatf("bp_hold%0d_p", k), {16'b0, res_p}, 132);
            check($sformatf("bp_hold%0d_id", k), {30'b0, res_id}, 1);
            check($sformatf("bp_hold%0d_ready", k), {28'b0, req_ready}, 0);
        end
        res_ready = 1'b1;
        tick();
        check("bp_hs_valid", {31'b0, res_valid}, 0);
        check("bp_next_ready", {28'b0, req_ready}, 32'b1000);
        wait_grant("bp3", 3);
        req_valid[3] = 1'b0;
        wait_result("bp3", 3, 42);

        // Reset at the 4th BUSY edge; leaves ptr=3 if reset fails to clear it
        set_req(2, 8'd5, 8'd5);
        wait_grant("mr", 2);
        req_valid[2] = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mr_busy", {31'b0, busy}, 0);
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (res_valid) seen = 1'b1;
        end
        check("mr_no_result", {31'b0, seen}, 0);
        set_req(2, 8'd9, 8'd13);
        set_req(3, 8'd2, 8'd2);
        wait_grant("mr2", 2);
        req_valid[2] = 1'b0;
        wait_result("mr2", 2, 117);
        wait_grant("mr3", 3);
        req_valid[3] = 1'b0;
        wait_result("mr3", 3, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
